// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - fetch/data arbiter for the shared single-port memory
// Data wins by default; a starvation counter forces a fetch grant after STARVE_MAX data wins.
module mem_port_arbiter #(
    parameter int AW         = 7,
    parameter int DW         = 32,
    parameter int MEM_LAT    = 2,
    parameter int STARVE_MAX = 3
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          if_req,
    input  logic [AW-1:0] if_addr,
    output logic          if_gnt,
    output logic          if_rvalid,
    output logic [DW-1:0] if_rdata,
    input  logic          dm_req,
    input  logic          dm_we,
    input  logic [AW-1:0] dm_addr,
    input  logic [DW-1:0] dm_wdata,
    output logic          dm_gnt,
    output logic          dm_rvalid,
    output logic [DW-1:0] dm_rdata,
    input  logic          halt,
    output logic          mem_en,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata,
    output logic          busy
);

    typedef enum logic {S_IDLE, S_WAIT} state_t;

    localparam logic [3:0] LAT4  = 4'(MEM_LAT);
    localparam logic [3:0] SMAX4 = 4'(STARVE_MAX);

    state_t     state;
    logic [3:0] cnt;
    logic [3:0] starve;
    logic       owner;      // 1 = data port owns the access in flight
    logic       we_q;
    logic       idle_ok;
    logic       f_elig;
    logic       fetch_win;
    logic       data_win;

    always_comb begin
        idle_ok   = (state == S_IDLE) && !rst;
        f_elig    = if_req && !halt;
        fetch_win = idle_ok && f_elig && (!dm_req || (starve == SMAX4));
        data_win  = idle_ok && dm_req && !fetch_win;
    end

    assign if_gnt    = fetch_win;
    assign dm_gnt    = data_win;
    assign mem_en    = fetch_win || data_win;
    assign mem_we    = data_win && dm_we;
    assign mem_addr  = data_win ? dm_addr : (fetch_win ? if_addr : '0);
    assign mem_wdata = data_win ? dm_wdata : '0;
    assign busy      = (state == S_WAIT);

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_IDLE;
            cnt       <= 4'd0;
            starve    <= 4'd0;
            owner     <= 1'b0;
            we_q      <= 1'b0;
            if_rvalid <= 1'b0;
            if_rdata  <= '0;
            dm_rvalid <= 1'b0;
            dm_rdata  <= '0;
        end else begin
            if_rvalid <= 1'b0;
            dm_rvalid <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (fetch_win || data_win) begin
                        owner <= data_win;
                        we_q  <= data_win && dm_we;
                        cnt   <= LAT4;
                        state <= S_WAIT;
                        // Only a data win over a waiting fetch counts toward starvation.
                        if (data_win && f_elig)
                            starve <= (starve >= SMAX4) ? SMAX4 : starve + 4'd1;
                        else
                            starve <= 4'd0;
                    end
                end
                S_WAIT: begin
                    cnt <= cnt - 4'd1;
                    if (cnt == 4'd1) begin
                        state <= S_IDLE;
                        if (owner) begin
                            dm_rvalid <= 1'b1;
                            dm_rdata  <= we_q ? '0 : mem_rdata;
                        end else begin
                            if_rvalid <= 1'b1;
                            if_rdata  <= mem_rdata;
                        end
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - directed bench with response scoreboard for mem_port_arbiter
module tb_mem_port_arbiter;

    localparam int AW = 7;
    localparam int DW = 32;
    localparam int MEM_LAT = 2;
    localparam int STARVE_MAX = 3;

    logic          clk = 1'b0;
    logic          rst;
    logic          if_req;
    logic [AW-1:0] if_addr;
    logic          if_gnt;
    logic          if_rvalid;
    logic [DW-1:0] if_rdata;
    logic          dm_req;
    logic          dm_we;
    logic [AW-1:0] dm_addr;
    logic [DW-1:0] dm_wdata;
    logic          dm_gnt;
    logic          dm_rvalid;
    logic [DW-1:0] dm_rdata;
    logic          halt;
    logic          mem_en;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;
    logic          busy;

    int tests = 0;
    int fails = 0;

    logic [DW-1:0] mem     [0:102];
    logic [DW-1:0] ref_mem [0:102];
    logic [DW-1:0] rd_pipe [0:MEM_LAT-1];
    logic [DW-1:0] if_q [$];
    logic [DW-1:0] dm_q [$];

    always #5 clk = ~clk;

    mem_port_arbiter #(.AW(AW), .DW(DW), .MEM_LAT(MEM_LAT), .STARVE_MAX(STARVE_MAX)) dut (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt),
        .if_rvalid(if_rvalid), .if_rdata(if_rdata),
        .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
        .dm_gnt(dm_gnt), .dm_rvalid(dm_rvalid), .dm_rdata(dm_rdata),
        .halt(halt),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
        .busy(busy)
    );

    // Memory with fixed read latency
    always @(posedge clk) begin
        if (mem_en && mem_we) mem[mem_addr] <= mem_wdata;
        rd_pipe[0] <= mem_en ? mem[mem_addr] : 'x;
        for (int i = 1; i < MEM_LAT; i++) rd_pipe[i] <= rd_pipe[i-1];
    end
    assign mem_rdata = rd_pipe[MEM_LAT-1];

    task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Scoreboard: expectations pushed when a request is accepted, popped on rvalid
    always @(negedge clk) begin
        if (rst) begin
            if_q.delete();
            dm_q.delete();
        end else begin
            if (if_rvalid) begin
                tests++;
                assert (if_q.size() != 0) else begin
                    fails++;
                    $error("FAIL if_rvalid_unexpected: observed rvalid expected none");
                end
                if (if_q.size() != 0) chk("if_rdata", if_rdata, if_q.pop_front());
            end
            if (dm_rvalid) begin
                tests++;
                assert (dm_q.size() != 0) else begin
                    fails++;
                    $error("FAIL dm_rvalid_unexpected: observed rvalid expected none");
                end
                if (dm_q.size() != 0) chk("dm_rdata", dm_rdata, dm_q.pop_front());
            end
            if (if_gnt) if_q.push_back(ref_mem[if_addr]);
            if (dm_gnt) begin
                if (dm_we) begin
                    dm_q.push_back('0);
                    ref_mem[dm_addr] = dm_wdata;
                end else begin
                    dm_q.push_back(ref_mem[dm_addr]);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #2;
    endtask

    initial begin
        for (int i = 0; i < 103; i++) begin
            mem[i]     = (32'(i) * 32'h01010101) ^ 32'hA5A50000;
            ref_mem[i] = (32'(i) * 32'h01010101) ^ 32'hA5A50000;
        end
        mem[5] = 32'h2801000a;
        ref_mem[5] = 32'h2801000a;
        for (int i = 0; i < MEM_LAT; i++) rd_pipe[i] = '0;
        rst = 1'b1; if_req = 0; if_addr = 0; dm_req = 0; dm_we = 0;
        dm_addr = 0; dm_wdata = 0; halt = 0;
        tick(); tick();
        if_req = 1; dm_req = 1; settle();
        chk("rst_if_gnt", {31'b0, if_gnt}, 0);
        chk("rst_mem_en", {31'b0, mem_en}, 0);
        chk("rst_busy", {31'b0, busy}, 0);
        chk("rst_rdata", if_rdata | dm_rdata, 0);
        tick();
        rst = 0; if_req = 0; dm_req = 0;
        tick();

        // Single fetch, latency 2
        if_req = 1; if_addr = 5; settle();
        chk("t2_if_gnt_c0", {31'b0, if_gnt}, 1);
        chk("t2_mem_en_c0", {31'b0, mem_en}, 1);
        chk("t2_mem_addr_c0", {25'b0, mem_addr}, 5);
        tick(); if_req = 0; settle();
        chk("t2_busy_c1", {31'b0, busy}, 1);
        tick(); settle();
        chk("t2_busy_c2", {31'b0, busy}, 1);
        chk("t2_rvalid_c2", {31'b0, if_rvalid}, 0);
        tick(); settle();
        chk("t2_rvalid_c3", {31'b0, if_rvalid}, 1);
        chk("t2_rdata_c3", if_rdata, 32'h2801000a);
        chk("t2_busy_c3", {31'b0, busy}, 0);
        tick();

        // Fetch and load together: data first
        if_req = 1; if_addr = 0; dm_req = 1; dm_we = 0; dm_addr = 20; settle();
        chk("t3_dm_gnt_c0", {31'b0, dm_gnt}, 1);
        chk("t3_if_gnt_c0", {31'b0, if_gnt}, 0);
        tick(); dm_req = 0; settle();
        chk("t3_if_gnt_c1", {31'b0, if_gnt}, 0);
        tick(); settle();
        tick(); settle();
        chk("t3_dm_rvalid_c3", {31'b0, dm_rvalid}, 1);
        chk("t3_if_gnt_c3", {31'b0, if_gnt}, 1);
        tick(); if_req = 0; settle();
        tick(); tick(); settle();
        chk("t3_if_rvalid_c6", {31'b0, if_rvalid}, 1);
        tick();

        // Starvation: data at 0,3,6, fetch at 9, data at 12
        if_req = 1; if_addr = 7; dm_req = 1; dm_we = 0; dm_addr = 40;
        for (int k = 0; k < 15; k++) begin
            settle();
            chk($sformatf("t4_dm_gnt_c%0d", k), {31'b0, dm_gnt},
                (k == 0 || k == 3 || k == 6 || k == 12) ? 32'd1 : 32'd0);
            chk($sformatf("t4_if_gnt_c%0d", k), {31'b0, if_gnt}, (k == 9) ? 32'd1 : 32'd0);
            tick();
            if (k == 12) begin if_req = 0; dm_req = 0; end
        end
        tick();

        // Store then load back
        dm_req = 1; dm_we = 1; dm_addr = 10; dm_wdata = 32'h1234; settle();
        chk("t5_mem_we_c0", {31'b0, mem_we}, 1);
        chk("t5_mem_en_c0", {31'b0, mem_en}, 1);
        chk("t5_mem_wdata_c0", mem_wdata, 32'h1234);
        tick(); dm_req = 0; dm_we = 0; settle();
        tick(); tick();
        dm_req = 1; dm_we = 0; dm_addr = 10; settle();
        chk("t5_dm_rvalid_c3", {31'b0, dm_rvalid}, 1);
        chk("t5_dm_rdata_c3", dm_rdata, 0);
        chk("t5_ld_gnt_c3", {31'b0, dm_gnt}, 1);
        tick(); dm_req = 0; tick(); tick(); settle();
        chk("t5_ld_rvalid_c6", {31'b0, dm_rvalid}, 1);
        chk("t5_ld_rdata_c6", dm_rdata, 32'h1234);
        tick();

        // halt blocks fetch and keeps starve at 0
        halt = 1; if_req = 1; if_addr = 3; dm_req = 1; dm_addr = 30;
        for (int k = 0; k < 24; k++) begin
            if (k == 10) halt = 0;
            settle();
            chk($sformatf("t6_if_gnt_c%0d", k), {31'b0, if_gnt}, (k == 21) ? 32'd1 : 32'd0);
            chk($sformatf("t6_dm_gnt_c%0d", k), {31'b0, dm_gnt},
                (k % 3 == 0 && k != 21) ? 32'd1 : 32'd0);
            tick();
            if (k == 21) begin if_req = 0; dm_req = 0; end
        end
        tick();

        // Fetch alone under halt, then released; in-flight fetch survives halt
        halt = 1; if_req = 1; if_addr = 9; settle();
        chk("t6b_halt_if_gnt", {31'b0, if_gnt}, 0);
        tick(); halt = 0; settle();
        chk("t6b_release_if_gnt", {31'b0, if_gnt}, 1);
        tick(); if_req = 0; halt = 1; tick(); tick(); settle();
        chk("t6b_if_rvalid_halted", {31'b0, if_rvalid}, 1);
        tick(); halt = 0;

        // Reset mid-access drops the response
        dm_req = 1; dm_addr = 50; if_req = 1; if_addr = 2; settle();
        chk("t1_gnt_before_rst", {31'b0, dm_gnt}, 1);
        tick(); dm_req = 0; if_req = 0; rst = 1;
        for (int k = 0; k < 2; k++) begin
            dm_req = 1; settle();
            chk("t1_rst_dm_gnt", {31'b0, dm_gnt}, 0);
            chk("t1_rst_mem_en", {31'b0, mem_en}, 0);
            tick();
            chk("t1_rst_busy", {31'b0, busy}, 0);
            chk("t1_rst_rvalid", {30'b0, if_rvalid, dm_rvalid}, 0);
        end
        rst = 0; dm_req = 0;
        for (int k = 0; k < 5; k++) begin
            settle();
            chk("t1_post_rvalid", {30'b0, if_rvalid, dm_rvalid}, 0);
            tick();
        end

        chk("sb_if_empty", 32'(if_q.size()), 0);
        chk("sb_dm_empty", 32'(dm_q.size()), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
